// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, Set-2 prefix bytes and
// keyboard status/response bytes that carry no key information.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BRK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;

    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_BAT    = 8'hAA;
    localparam logic [7:0] IGN_ECHO   = 8'hEE;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_ERR0   = 8'h00;
    localparam logic [7:0] IGN_ERR1   = 8'hFF;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == IGN_ACK) || (b == IGN_BAT) || (b == IGN_ECHO) ||
               (b == IGN_RESEND) || (b == IGN_ERR0) || (b == IGN_ERR1);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output only
// follows the line once FILTER_LEN consecutive samples disagree with it.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames 11-bit device-to-host words and decodes
// Set-2 make/break/extended sequences into key events.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       keypress,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          w_clk_f;
    logic          w_dat_f;
    logic          w_fall;
    logic          w_frame_ok;

    ps2_state_t    r_state;
    logic          r_clk_prev;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic          r_brk;
    logic          r_ext;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .i_raw(ps2_clk), .o_filt(w_clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk), .reset(reset), .i_raw(ps2_data), .o_filt(w_dat_f)
    );

    assign w_fall     = r_clk_prev & ~w_clk_f;
    // Odd parity over data+parity, and the stop bit sampled on this edge.
    assign w_frame_ok = (^{r_shift, r_parity}) & w_dat_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clk_prev <= 1'b1;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tcnt     <= '0;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            keycode    <= '0;
            keypress   <= 1'b0;
            key_ext    <= 1'b0;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;

            // A stalled keyboard mid-frame is dropped silently.
            if (r_state != ST_IDLE && !w_fall) begin
                if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= ST_IDLE;
                    r_tcnt  <= '0;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end else begin
                r_tcnt <= '0;
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat_f) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_dat_f, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_parity <= w_dat_f;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_frame_ok) begin
                            frame_err <= 1'b1;
                            r_brk     <= 1'b0;
                            r_ext     <= 1'b0;
                        end else if (r_shift == BRK_PREFIX) begin
                            r_brk <= 1'b1;
                        end else if (r_shift == EXT_PREFIX) begin
                            r_ext <= 1'b1;
                        end else if (!is_ignored(r_shift)) begin
                            keycode   <= r_shift;
                            keypress  <= ~r_brk;
                            key_ext   <= r_ext;
                            key_valid <= 1'b1;
                            r_brk     <= 1'b0;
                            r_ext     <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and random PS/2 frames checked against a byte-level decode model.
module tb_ps2_keyboard_rx;
    localparam int FL   = 8;
    localparam int TO   = 200;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       keypress;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    logic [9:0] ev_q[$];
    logic [9:0] exp_q[$];
    int ferr_cnt  = 0;
    int exp_ferr  = 0;
    int both_cnt  = 0;

    logic [7:0] m_keycode = 8'h00;
    logic       m_press   = 1'b0;
    logic       m_kext    = 1'b0;
    logic       m_brk     = 1'b0;
    logic       m_ext     = 1'b0;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .keypress(keypress), .key_ext(key_ext),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) ev_q.push_back({key_ext, keypress, keycode});
        if (frame_err) ferr_cnt++;
        if (key_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        wait_clks(HALF); #1 ps2_clk = 1'b0;
        wait_clks(HALF); #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic perr, input logic serr);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ perr);
        send_bit(~serr);
        @(posedge clk); #1 ps2_data = 1'b1;
        wait_clks(20);
    endtask

    // Byte-level decode rules: prefixes set flags, status bytes vanish,
    // anything else is a key event that consumes the flags.
    task automatic model_frame(input logic [7:0] b, input logic err);
        if (err) begin
            exp_ferr++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            m_keycode = b;
            m_press   = ~m_brk;
            m_kext    = m_ext;
            exp_q.push_back({m_kext, m_press, b});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_nev"}, ev_q.size(), exp_q.size());
        if (ev_q.size() == exp_q.size()) begin
            while (exp_q.size() > 0) chk({tag, "_ev"}, int'(ev_q.pop_front()), int'(exp_q.pop_front()));
        end else begin
            ev_q.delete();
            exp_q.delete();
        end
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_keycode"}, int'(keycode), int'(m_keycode));
        chk({tag, "_keypress"}, int'(keypress), int'(m_press));
        chk({tag, "_key_ext"}, int'(key_ext), int'(m_kext));
    endtask

    task automatic frame(input logic [7:0] b, input logic perr, input logic serr, input string tag);
        send_frame(b, perr, serr);
        model_frame(b, perr | serr);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       pe;
        logic       se;
        logic [7:0] ign [6];
        ign = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clks(3);
        @(negedge clk);
        chk("rst_keycode", int'(keycode), 0);
        chk("rst_keypress", int'(keypress), 0);
        chk("rst_key_ext", int'(key_ext), 0);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        #1 reset = 1'b0;
        wait_clks(20);

        frame(8'h1C, 1'b0, 1'b0, "make");
        frame(8'hF0, 1'b0, 1'b0, "brk_pre");
        frame(8'h1C, 1'b0, 1'b0, "brk");
        frame(8'hE0, 1'b0, 1'b0, "ext_pre");
        frame(8'hF0, 1'b0, 1'b0, "ext_brk_pre");
        frame(8'h75, 1'b0, 1'b0, "ext_brk");
        frame(8'h75, 1'b0, 1'b0, "make75");
        frame(8'h5A, 1'b1, 1'b0, "badpar");
        frame(8'h5A, 1'b0, 1'b0, "good5a");
        frame(8'h5A, 1'b0, 1'b0, "typematic");
        frame(8'hF0, 1'b0, 1'b0, "dbl_f0a");
        frame(8'hF0, 1'b0, 1'b0, "dbl_f0b");
        frame(8'h33, 1'b0, 1'b0, "dbl_f0key");
        frame(8'hE0, 1'b0, 1'b0, "badstop_pre");
        frame(8'h21, 1'b0, 1'b1, "badstop");
        frame(8'h21, 1'b0, 1'b0, "after_badstop");
        frame(8'hFA, 1'b0, 1'b0, "ignored");

        // Partial frame abandoned by inactivity.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        @(posedge clk); #1 ps2_data = 1'b1;
        wait_clks(TO + 5 + HALF);
        check_state("timeout");
        frame(8'h43, 1'b0, 1'b0, "post_timeout");

        // Clock glitch one sample short of the filter length, with data low.
        @(posedge clk); #1 ps2_data = 1'b0;
        wait_clks(20);
        @(posedge clk); #1 ps2_clk = 1'b0;
        repeat (FL - 1) @(posedge clk);
        #1 ps2_clk = 1'b1;
        wait_clks(5);
        #1 ps2_data = 1'b1;
        wait_clks(20);
        frame(8'h29, 1'b0, 1'b0, "post_glitch");

        // Reset mid-frame after an E0 prefix: flags and partial bits are lost.
        frame(8'hE0, 1'b0, 1'b0, "pre_rst_ext");
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("midrst_keycode", int'(keycode), 0);
        chk("midrst_keypress", int'(keypress), 0);
        chk("midrst_key_ext", int'(key_ext), 0);
        chk("midrst_key_valid", int'(key_valid), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        m_keycode = 8'h00; m_press = 1'b0; m_kext = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        wait_clks(5);
        #1 reset = 1'b0;
        wait_clks(20);
        frame(8'h2B, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hF0;
                1:       rb = 8'hE0;
                2:       rb = ign[$urandom_range(0, 5)];
                default: rb = 8'($urandom);
            endcase
            pe = ($urandom_range(0, 7) == 0);
            se = ($urandom_range(0, 15) == 0);
            frame(rb, pe, se, "rnd");
        end

        chk("valid_and_err", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
